// File: rtl/clk_en_gen_multi.sv
// clk_en_gen_multi: multi-channel fractional clock-enable generator.
// Each channel runs a modulo-CLK_IN phase accumulator. A strobe is emitted whenever the
// accumulator wraps. Rate writes are staged and take effect on the channel's next strobe.
// Optional feature macro: CLKEN_TOGGLE_EN adds a per-channel square-wave output oClkOut.
module clk_en_gen_multi #(
  parameter int unsigned CLK_IN   = 25000000,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned ACC_W    = 26,
  parameter int unsigned DEF_INC  = 3579545
) (
  input  logic                iClk,
  input  logic                iRst,
  input  logic                iWrEn,
  input  logic [3:0]          iWrChan,
  input  logic [ACC_W-1:0]    iWrData,
  input  logic [CHANNELS-1:0] iHold,
  output logic [CHANNELS-1:0] oClkEn,
  output logic [CHANNELS-1:0] oPending,
`ifdef CLKEN_TOGGLE_EN
  output logic [CHANNELS-1:0] oClkOut,
`endif
  output logic                oWrErr
);

  localparam logic [ACC_W:0]   ClkInExt = (ACC_W+1)'(CLK_IN);
  localparam logic [ACC_W-1:0] DefInc   = ACC_W'(DEF_INC);

  logic [ACC_W-1:0]    accum_q    [CHANNELS];
  logic [ACC_W-1:0]    accum_d    [CHANNELS];
  logic [ACC_W-1:0]    inc_q      [CHANNELS];
  logic [ACC_W-1:0]    inc_d      [CHANNELS];
  logic [ACC_W-1:0]    pend_inc_q [CHANNELS];
  logic [ACC_W-1:0]    pend_inc_d [CHANNELS];
  logic [ACC_W:0]      sum        [CHANNELS];
  logic [CHANNELS-1:0] pend_q, pend_d;
  logic [CHANNELS-1:0] en_q, en_d;
  logic [CHANNELS-1:0] wr_sel;
  logic                wr_bad;
  logic                wr_err_q, wr_err_d;

  // Decode the write port: which channel is addressed and whether the rate is out of range.
  always_comb begin
    wr_bad = ({1'b0, iWrData} >= ClkInExt);
    for (int c = 0; c < int'(CHANNELS); c++) begin
      wr_sel[c] = iWrEn && (iWrChan == 4'(c));
    end
    // Writes to nonexistent channels decode to no wr_sel bit, so they never raise an error.
    wr_err_d = (|wr_sel) && wr_bad;
  end

  // Per-channel accumulate, strobe, and staged-rate application.
  always_comb begin
    for (int c = 0; c < int'(CHANNELS); c++) begin
      accum_d[c]    = accum_q[c];
      inc_d[c]      = inc_q[c];
      pend_inc_d[c] = pend_inc_q[c];
      pend_d[c]     = pend_q[c];
      en_d[c]       = 1'b0;
      sum[c]        = {1'b0, accum_q[c]} + {1'b0, inc_q[c]};
      if (inc_q[c] == '0) begin
        // A stopped channel never strobes, so a staged rate is taken at once, even when held.
        if (pend_q[c]) begin
          inc_d[c]  = pend_inc_q[c];
          pend_d[c] = 1'b0;
        end
      end else if (!iHold[c]) begin
        if (sum[c] >= ClkInExt) begin
          accum_d[c] = ACC_W'(sum[c] - ClkInExt);
          en_d[c]    = 1'b1;
          if (pend_q[c]) begin
            inc_d[c]  = pend_inc_q[c];
            pend_d[c] = 1'b0;
          end
        end else begin
          accum_d[c] = sum[c][ACC_W-1:0];
        end
      end
      // A same-cycle write lands after any application above, so it stays pending.
      if (wr_sel[c] && !wr_bad) begin
        pend_inc_d[c] = iWrData;
        pend_d[c]     = 1'b1;
      end
    end
  end

  // Channel state registers.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      for (int c = 0; c < int'(CHANNELS); c++) begin
        accum_q[c]    <= '0;
        inc_q[c]      <= DefInc;
        pend_inc_q[c] <= '0;
      end
      pend_q   <= '0;
      en_q     <= '0;
      wr_err_q <= 1'b0;
    end else begin
      for (int c = 0; c < int'(CHANNELS); c++) begin
        accum_q[c]    <= accum_d[c];
        inc_q[c]      <= inc_d[c];
        pend_inc_q[c] <= pend_inc_d[c];
      end
      pend_q   <= pend_d;
      en_q     <= en_d;
      wr_err_q <= wr_err_d;
    end
  end

`ifdef CLKEN_TOGGLE_EN
  logic [CHANNELS-1:0] tog_q;

  // Square wave: flips in the same cycle the channel's strobe is high.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      tog_q <= '0;
    end else begin
      tog_q <= tog_q ^ en_d;
    end
  end

  assign oClkOut = tog_q;
`endif

  assign oClkEn   = en_q;
  assign oPending = pend_q;
  assign oWrErr   = wr_err_q;

endmodule

// File: tb/tb_clk_en_gen_multi.sv
// Bench for clk_en_gen_multi with CLK_IN=10, CHANNELS=4, DEF_INC=3.
// Directed scenarios with literal expectations, then randomized traffic checked every cycle
// against a modulo-arithmetic reference model.
module tb_clk_en_gen_multi;

  localparam int CLK = 10;
  localparam int CH  = 4;
  localparam int AW  = 5;
  localparam int DI  = 3;

  logic          iClk = 1'b0;
  logic          iRst;
  logic          iWrEn;
  logic [3:0]    iWrChan;
  logic [AW-1:0] iWrData;
  logic [CH-1:0] iHold;
  logic [CH-1:0] oClkEn;
  logic [CH-1:0] oPending;
  logic          oWrErr;
`ifdef CLKEN_TOGGLE_EN
  logic [CH-1:0] oClkOut;
`endif

  clk_en_gen_multi #(
    .CLK_IN  (CLK),
    .CHANNELS(CH),
    .ACC_W   (AW),
    .DEF_INC (DI)
  ) dut (
    .iClk    (iClk),
    .iRst    (iRst),
    .iWrEn   (iWrEn),
    .iWrChan (iWrChan),
    .iWrData (iWrData),
    .iHold   (iHold),
    .oClkEn  (oClkEn),
    .oPending(oPending),
`ifdef CLKEN_TOGGLE_EN
    .oClkOut (oClkOut),
`endif
    .oWrErr  (oWrErr)
  );

  always #5 iClk = ~iClk;

  // Reference model: phase in [0, CLK), rate in Hz, staged rate.
  int m_phase [CH];
  int m_rate  [CH];
  int m_next  [CH];
  bit m_pend  [CH];
  bit m_en    [CH];
  bit m_tog   [CH];
  bit m_err;

  int total = 0;
  int bad   = 0;
  int edge_no;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_phase[c] = 0;
      m_rate[c]  = DI;
      m_next[c]  = 0;
      m_pend[c]  = 0;
      m_en[c]    = 0;
      m_tog[c]   = 0;
    end
    m_err = 0;
  endtask

  // One clock edge of the specified behaviour, from the inputs as sampled at that edge.
  task automatic model_step();
    int wch;
    int wd;
    bit staged;
    int staged_rate;
    if (iRst) begin
      model_reset();
      return;
    end
    wch   = int'(iWrChan);
    wd    = int'(iWrData);
    m_err = iWrEn && (wch < CH) && (wd >= CLK);
    for (int c = 0; c < CH; c++) begin
      staged      = m_pend[c];
      staged_rate = m_next[c];
      m_en[c]     = 0;
      if (m_rate[c] == 0) begin
        if (staged) begin
          m_rate[c] = staged_rate;
          m_pend[c] = 0;
        end
      end else if (!iHold[c]) begin
        m_en[c]    = (m_phase[c] + m_rate[c]) >= CLK;
        m_phase[c] = (m_phase[c] + m_rate[c]) % CLK;
        if (m_en[c] && staged) begin
          m_rate[c] = staged_rate;
          m_pend[c] = 0;
        end
      end
      if (iWrEn && wch == c && wd < CLK) begin
        m_next[c] = wd;
        m_pend[c] = 1;
      end
      m_tog[c] = m_tog[c] ^ m_en[c];
    end
  endtask

  task automatic compare_all();
    logic [CH-1:0] e_en;
    logic [CH-1:0] e_pd;
    logic [CH-1:0] e_tg;
    for (int c = 0; c < CH; c++) begin
      e_en[c] = m_en[c];
      e_pd[c] = m_pend[c];
      e_tg[c] = m_tog[c];
    end
    chk("clk_en", 32'(oClkEn), 32'(e_en));
    chk("pending", 32'(oPending), 32'(e_pd));
    chk("wr_err", 32'(oWrErr), 32'(m_err));
`ifdef CLKEN_TOGGLE_EN
    chk("clk_out", 32'(oClkOut), 32'(e_tg));
`else
    if (e_tg === 'x) $display("unreachable");
`endif
  endtask

  // Drive inputs (called at a falling edge), take one rising edge, check at the next fall.
  task automatic cyc(input bit we, input int ch, input int d, input logic [CH-1:0] h);
    iWrEn   = we;
    iWrChan = 4'(ch);
    iWrData = AW'(d);
    iHold   = h;
    @(posedge iClk);
    model_step();
    @(negedge iClk);
    compare_all();
    edge_no++;
  endtask

  task automatic do_reset();
    iRst  = 1'b1;
    iWrEn = 1'b0;
    iHold = '0;
    model_reset();
    #1;
    chk("rst_clk_en", 32'(oClkEn), 32'd0);
    chk("rst_pending", 32'(oPending), 32'd0);
    chk("rst_wr_err", 32'(oWrErr), 32'd0);
    @(negedge iClk);
    iRst    = 1'b0;
    edge_no = 0;
  endtask

  initial begin
    int s0;
    bit seen;
    logic [CH-1:0] h;
    iRst    = 1'b1;
    iWrEn   = 1'b0;
    iWrChan = '0;
    iWrData = '0;
    iHold   = '0;
    model_reset();
    repeat (3) @(negedge iClk);
    do_reset();

    // Basic rate: strobes at edges 4,7,10,14,17,20 and 300 strobes in 1000 edges.
    s0 = 0;
    for (int k = 1; k <= 1000; k++) begin
      cyc(0, 0, 0, '0);
      if (k <= 20) chk("basic_edge", 32'(oClkEn[0]), 32'(k inside {4, 7, 10, 14, 17, 20}));
      s0 += int'(oClkEn[0]);
    end
    chk("basic_count", 32'(s0), 32'd300);

    // Glitch-free rate change on ch0: write 5 sampled at edge 6.
    do_reset();
    repeat (5) cyc(0, 0, 0, '0);
    cyc(1, 0, 5, '0);
    chk("chg_pend_rise", 32'(oPending[0]), 32'd1);
    cyc(0, 0, 0, '0);
    chk("chg_old_strobe", 32'(oClkEn[0]), 32'd1);
    chk("chg_pend_fall", 32'(oPending[0]), 32'd0);
    for (int k = 8; k <= 13; k++) begin
      cyc(0, 0, 0, '0);
      chk("chg_new_rate", 32'(oClkEn[0]), 32'(k % 2));
    end

    // Rejected write and out-of-range channel write.
    cyc(1, 1, 10, '0);
    chk("rej_err", 32'(oWrErr), 32'd1);
    chk("rej_pend", 32'(oPending[1]), 32'd0);
    cyc(1, 7, 3, '0);
    chk("bad_chan_err", 32'(oWrErr), 32'd0);
    chk("bad_chan_pend", 32'(oPending), 32'd0);
    repeat (10) cyc(0, 0, 0, '0);

    // Hold ch1 mid-period; other channels keep running (model-checked).
    for (int k = 0; k < 20; k++) begin
      cyc(0, 0, 0, 4'b0010);
      chk("hold_quiet", 32'(oClkEn[1]), 32'd0);
    end
    repeat (20) cyc(0, 0, 0, '0);

    // Stop ch2 with rate 0, then restart with rate 4.
    cyc(1, 2, 0, '0);
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      cyc(0, 0, 0, '0);
      seen = oClkEn[2];
    end
    chk("stop_last_strobe", 32'(seen), 32'd1);
    for (int k = 0; k < 12; k++) begin
      cyc(0, 0, 0, '0);
      chk("stopped_quiet", 32'(oClkEn[2]), 32'd0);
    end
    cyc(1, 2, 4, 4'b0100);
    chk("restart_pend", 32'(oPending[2]), 32'd1);
    cyc(0, 0, 0, 4'b0100);
    chk("restart_applied", 32'(oPending[2]), 32'd0);
    repeat (10) cyc(0, 0, 0, '0);

    // Reset mid-period, then first strobe at edge 4.
    repeat (2) cyc(0, 0, 0, '0);
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      cyc(0, 0, 0, '0);
      chk("post_rst_first", 32'(oClkEn[0]), 32'(k == 4));
    end

    // Randomized traffic.
    h = '0;
    for (int k = 0; k < 4000; k++) begin
      bit we;
      int ch;
      int d;
      we = ($urandom_range(0, 3) == 0);
      ch = $urandom_range(0, 7);
      d  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 9);
      if ($urandom_range(0, 15) == 0) h = CH'($urandom) & CH'($urandom);
      if ($urandom_range(0, 499) == 0) iRst = 1'b1;
      cyc(we, ch, d, h);
      iRst = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clk_en_gen_multi.md
# clk_en_gen_multi

Multi-channel fractional clock-enable generator. It is the parametrised successor to the single-rate enable generator, and produces CHANNELS independent one-cycle enable strobes from one system clock. Each channel's rate is programmable at run time and can be frozen. Rate changes are applied glitch-free on the channel's next strobe. Peripheral timing (CPU turbo/normal rate, PIT, audio, UART baud) hangs off these strobes.

## Interface
- CLK_IN, 25000000: system clock frequency in Hz; this is the accumulator modulus.
- CHANNELS, 4: number of independent enable channels (1..16).
- ACC_W, 26: accumulator width. Must satisfy 2^ACC_W > 2*CLK_IN.
- DEF_INC, 3579545: increment loaded into every channel on reset (output rate in Hz).
- iClk  in  1  system clock; all logic on rising edge.
- iRst  in  1  asynchronous reset, active-high.
- iWrEn  in  1  rate write strobe, one cycle.
- iWrChan  in  4  channel index for the write; indices >= CHANNELS are ignored.
- iWrData  in  ACC_W  new increment (Hz).
- iHold  in  CHANNELS  per-channel freeze.
- oClkEn  out  CHANNELS  per-channel enable strobes, registered.
- oPending  out  CHANNELS  per-channel flag: a written rate is waiting to be applied.
- oWrErr  out  1  one-cycle pulse when a write is rejected.

## Operation
- Per-channel state:
  - accum[ACC_W], reset 0.
  - inc[ACC_W], reset DEF_INC.
  - pend_inc[ACC_W], reset 0.
  - pend flag, reset 0.
  - en, reset 0.
- Each cycle, for a channel that is not held:
  - Compute sum = accum + inc in ACC_W+1 bits.
  - If sum >= CLK_IN: accum <= sum - CLK_IN and en <= 1.
  - Otherwise: accum <= sum and en <= 0.
- Long-run strobe rate is exactly inc/CLK_IN per cycle, with no cumulative drift.
- inc = 0 means the channel is stopped: en stays 0 and accum is unchanged.
- Held channel (iHold[c]=1):
  - accum is frozen and en <= 0.
  - A pending rate is not applied, except under the inc = 0 rule below.
  - On release, accumulation resumes from the frozen accum.
- Write acceptance (iWrEn=1, iWrChan < CHANNELS):
  - If iWrData >= CLK_IN, the write is rejected: oWrErr pulses for 1 cycle and no state changes.
  - Otherwise pend_inc <= iWrData and pend <= 1.
  - A second write while a rate is pending overwrites pend_inc; the last accepted write wins.
- Pending application:
  - On any cycle where the channel strobes (en <= 1), inc <= pend_inc and pend <= 0.
  - The strobe itself is produced with the old inc.
  - If the current inc = 0, the pending rate is applied on the next cycle regardless of hold. accum is not cleared.
- Simultaneous strobe and write on the same channel: the strobe applies the previously pending value (if any). The new write then becomes pending (pend stays 1).
- A write with iWrChan >= CHANNELS is silently ignored; oWrErr stays 0.
- oPending[c] = pend for channel c.

## Timing
- All outputs are registered.
- Reset values: oClkEn = 0, oPending = 0, oWrErr = 0.
- Reset asserted mid-operation immediately clears all state. Every channel restarts from accum = 0 with inc = DEF_INC.
- First strobe after reset release with increment I: oClkEn high after edge k = ceil(CLK_IN/I), counting the first edge after release as 1.
- Each strobe is exactly one cycle wide. Consecutive strobes are possible only if inc > CLK_IN/2.
- Write latency:
  - oPending rises 1 cycle after the iWrEn edge.
  - The new rate governs accumulation from the cycle after the next strobe.
  - oPending falls together with that strobe.
- oWrErr is high for the single cycle after the rejected write edge.

## Configuration
- CLKEN_TOGGLE_EN defined:
  - Adds output oClkOut [CHANNELS], reset 0.
  - Each bit toggles on the cycle its channel's oClkEn is high, giving a square wave at inc/2 Hz, for audio/PIT pin drive.
  - Held or stopped channels keep their level.
- CLKEN_TOGGLE_EN undefined: the port and its flops are absent; behaviour is otherwise identical.

## Test plan
- Basic rate: CLK_IN=10, DEF_INC=3, reset, release.
  - Strobes at edges 4, 7, 10, 14, 17, 20, …
  - Exactly 3 strobes per 10 cycles over 1000 cycles.
- Glitch-free change: ch0 inc=3, write 5 at edge 5.
  - oPending[0]=1 from edge 6.
  - Strobe at edge 7 uses the old rate, and oPending falls with it.
  - Strobes then follow every 2 cycles.
- Rejection: write iWrData=10 (CLK_IN=10) → oWrErr pulses 1 cycle, inc unchanged, oPending stays 0. Write to channel 7 with CHANNELS=4 → no effect, oWrErr stays 0.
- Hold: hold ch1 for 20 cycles mid-period.
  - No strobes during the hold.
  - After release, the next strobe comes at the cycle count remaining from the frozen accum.
  - Other channels are unaffected.
- Stop/restart and reset: write 0 → strobes stop after the next strobe. Write 4 → applied next cycle. Assert iRst mid-period → all outputs 0 immediately, and the first strobe after release is at edge ceil(10/3)=4.
- With CLKEN_TOGGLE_EN: inc=5, CLK_IN=10 → oClkOut toggles every 2 cycles, and holds its level while iHold=1.
